// File: rtl/alu_issue_stage.sv
// Operand issue/retire stage around a combinational ALU: input FIFO, ALU drive from the head,
// registered result with valid/ready handshake. Define ALU_ISSUE_STATS_EN to add retire/overflow counters.
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_control_t;
endpackage

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  alu_control_t             in_control,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output alu_control_t             alu_control,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    input  logic [N-1:0]             alu_result,
    input  logic                     alu_overflow,
    input  logic                     alu_zero,
    input  logic                     alu_equal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output alu_control_t             out_control,
    output logic [N-1:0]             out_result,
    output logic                     out_overflow,
    output logic                     out_zero,
    output logic                     out_equal,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]              retired_count,
    output logic [31:0]              overflow_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [N-1:0]   mem_a_q [DEPTH];
    logic [N-1:0]   mem_a_d [DEPTH];
    logic [N-1:0]   mem_b_q [DEPTH];
    logic [N-1:0]   mem_b_d [DEPTH];
    alu_control_t   mem_c_q [DEPTH];
    alu_control_t   mem_c_d [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           out_valid_q, out_valid_d;
    alu_control_t   out_control_q, out_control_d;
    logic [N-1:0]   out_result_q, out_result_d;
    logic           out_overflow_q, out_overflow_d;
    logic           out_zero_q, out_zero_d;
    logic           out_equal_q, out_equal_d;

    logic           push_s;
    logic           pop_s;
    logic           out_free_s;
    logic           not_empty_s;

    // Handshake qualification; in_ready depends on occupancy only.
    assign in_ready    = (count_q < DEPTH_C);
    assign not_empty_s = (count_q != {CW{1'b0}});
    assign push_s      = in_valid && in_ready;
    assign out_free_s  = !out_valid_q || out_ready;
    assign pop_s       = not_empty_s && out_free_s;

    // Present the FIFO head to the ALU, or a quiet operation when empty.
    always_comb begin
        alu_a       = {N{1'b0}};
        alu_b       = {N{1'b0}};
        alu_control = ALU_ADD;
        if (not_empty_s) begin
            alu_a       = mem_a_q[rd_ptr_q];
            alu_b       = mem_b_q[rd_ptr_q];
            alu_control = mem_c_q[rd_ptr_q];
        end else begin
            alu_a       = {N{1'b0}};
            alu_b       = {N{1'b0}};
            alu_control = ALU_ADD;
        end
    end

    // FIFO storage, pointer and occupancy next-state.
    always_comb begin
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        mem_c_d  = mem_c_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_a_d[wr_ptr_q] = in_a;
            mem_b_d[wr_ptr_q] = in_b;
            mem_c_d[wr_ptr_q] = in_control;
            wr_ptr_d          = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Output register: capture on pop, drop valid once consumed with nothing behind it.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_control_d  = out_control_q;
        out_result_d   = out_result_q;
        out_overflow_d = out_overflow_q;
        out_zero_d     = out_zero_q;
        out_equal_d    = out_equal_q;
        if (pop_s) begin
            out_valid_d    = 1'b1;
            out_control_d  = alu_control;
            out_result_d   = alu_result;
            out_overflow_d = alu_overflow;
            out_zero_d     = alu_zero;
            out_equal_d    = alu_equal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= {N{1'b0}};
                mem_b_q[i] <= {N{1'b0}};
                mem_c_q[i] <= ALU_ADD;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_a_q  <= mem_a_d;
            mem_b_q  <= mem_b_d;
            mem_c_q  <= mem_c_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_control_q  <= ALU_ADD;
            out_result_q   <= {N{1'b0}};
            out_overflow_q <= 1'b0;
            out_zero_q     <= 1'b0;
            out_equal_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_control_q  <= out_control_d;
            out_result_q   <= out_result_d;
            out_overflow_q <= out_overflow_d;
            out_zero_q     <= out_zero_d;
            out_equal_q    <= out_equal_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_control  = out_control_q;
    assign out_result   = out_result_q;
    assign out_overflow = out_overflow_q;
    assign out_zero     = out_zero_q;
    assign out_equal    = out_equal_q;
    assign count        = count_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating retire and overflow counters.
    always_comb begin
        retired_d = retired_q;
        ovf_cnt_d = ovf_cnt_q;
        if (pop_s && (retired_q != 32'hFFFF_FFFF)) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
        if (pop_s && alu_overflow && (ovf_cnt_q != 32'hFFFF_FFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 32'd1;
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
            ovf_cnt_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign retired_count  = retired_q;
    assign overflow_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the alu_* side.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    alu_control_t  in_control;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    alu_control_t  alu_control;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [31:0]   alu_result;
    logic          alu_overflow;
    logic          alu_zero;
    logic          alu_equal;
    logic          out_valid;
    logic          out_ready;
    alu_control_t  out_control;
    logic [31:0]   out_result;
    logic          out_overflow;
    logic          out_zero;
    logic          out_equal;
    logic [2:0]    count;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0]   retired_count;
    logic [31:0]   overflow_count;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [34:0] exp_q[$];

    alu_issue_stage #(.N(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control),
        .in_a(in_a), .in_b(in_b),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_equal(alu_equal),
        .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_zero(out_zero), .out_equal(out_equal), .count(count)
`ifdef ALU_ISSUE_STATS_EN
        , .retired_count(retired_count), .overflow_count(overflow_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] alu_fn(input alu_control_t c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (c)
            ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
            default: r = 32'd0;
        endcase
        return {v, r};
    endfunction

    // Behavioural ALU driven by the stage.
    always_comb begin
        logic [32:0] t;
        t            = alu_fn(alu_control, alu_a, alu_b);
        alu_result   = t[31:0];
        alu_overflow = t[32];
        alu_zero     = (t[31:0] == 32'd0);
        alu_equal    = (alu_a == alu_b);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with inputs set: logs accepted ops, checks retiring ones, advances one cycle.
    task automatic tick();
        logic [32:0] t;
        logic [34:0] e;
        if (in_valid && in_ready) begin
            t = alu_fn(in_control, in_a, in_b);
            exp_q.push_back({in_control, t[31:0]});
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("seq", 64'({out_control, out_result}), 64'(e));
            end
        end
        step();
    endtask

    task automatic drive(input alu_control_t c, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        in_control = c;
        in_a       = a;
        in_b       = b;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        int retired;
        int next_head;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_control = ALU_ADD;
        in_a       = 32'd0;
        in_b       = 32'd0;
        out_ready  = 1'b0;
        do_reset();

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_ctrl", 64'(out_control), 64'(ALU_ADD));
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_control), 64'(ALU_ADD));

        // Single ADD: 5 + 3
        out_ready = 1'b1;
        drive(ALU_ADD, 32'h0000_0005, 32'h0000_0003);
        step();
        in_valid = 1'b0;
        chk("add_valid_e0", 64'(out_valid), 64'd0);
        chk("add_count_e0", 64'(count), 64'd1);
        chk("add_alu_a", 64'(alu_a), 64'd5);
        chk("add_alu_b", 64'(alu_b), 64'd3);
        step();
        chk("add_valid_e1", 64'(out_valid), 64'd1);
        chk("add_result", 64'(out_result), 64'h8);
        chk("add_flags", 64'({out_overflow, out_zero, out_equal}), 64'd0);
        chk("add_count_e1", 64'(count), 64'd0);
        step();
        chk("add_valid_e2", 64'(out_valid), 64'd0);
        chk("add_result_hold", 64'(out_result), 64'h8);

        // Overflow
        do_reset();
        out_ready = 1'b1;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        in_valid = 1'b0;
        step();
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_result", 64'(out_result), 64'h8000_0000);
        chk("ovf_flag", 64'(out_overflow), 64'd1);
        chk("ovf_zero", 64'(out_zero), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
        chk("ovf_stat_ovf", 64'(overflow_count), 64'd1);
        chk("ovf_stat_ret", 64'(retired_count), 64'd1);
`endif

        // Back-pressure until full
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(ALU_SUB, 32'(i), 32'(i));
            chk("bp_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        drive(ALU_SUB, 32'd5, 32'd5);
        chk("bp_full_count", 64'(count), 64'd4);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_count", 64'(count), 64'd4);
            chk("bp_stall_out", 64'({out_valid, out_control, out_result, out_zero, out_equal}),
                64'({1'b1, ALU_SUB, 32'd0, 1'b1, 1'b1}));
            chk("bp_stall_head", 64'(alu_a), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        retired   = 0;
        next_head = 1;
        for (int k = 0; k < 12; k++) begin
            if (count != 3'd0) begin
                chk("bp_head_order", 64'(alu_a), 64'(next_head));
                next_head++;
            end
            if (out_valid) begin
                retired++;
                chk("bp_drain_vals", 64'({out_result, out_zero, out_equal}), 64'({32'd0, 1'b1, 1'b1}));
            end
            step();
        end
        chk("bp_retired", 64'(retired), 64'd5);

        // Streaming AND with wrap-around
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(ALU_AND, $urandom, $urandom);
            if (i >= 2) chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_count", 64'(count <= 3'd1), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Simultaneous push and pop at count=2
        do_reset();
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd100, 32'd1); tick();
        drive(ALU_ADD, 32'd200, 32'd2); tick();
        drive(ALU_ADD, 32'd300, 32'd3); tick();
        chk("pp_count_pre", 64'(count), 64'd2);
        chk("pp_valid_pre", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drive(ALU_XOR, 32'h0F0F_0000, 32'h00FF_0000); tick();
        chk("pp_count_d", 64'(count), 64'd2);
        drive(ALU_OR, 32'hA000_0000, 32'h0000_000A); tick();
        chk("pp_count_e", 64'(count), 64'd2);
        drive(ALU_SUB, 32'd7, 32'd9); tick();
        chk("pp_count_f", 64'(count), 64'd2);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
        chk("pp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ALU_ADD, 32'(i + 1), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("mr_count_pre", 64'(count), 64'd3);
        chk("mr_valid_pre", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 64'(out_valid), 64'd0);
        chk("mr_async_count", 64'(count), 64'd0);
        chk("mr_async_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("mr_no_stale", 64'(out_valid), 64'd0);
            step();
        end
        drive(ALU_ADD, 32'd10, 32'd20);
        step();
        in_valid = 1'b0;
        step();
        chk("mr_fresh", 64'({out_valid, out_result}), 64'({1'b1, 32'd30}));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
